// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the fetch-stage state type.
package cpu_pkg;

   localparam int unsigned ADDR_W  = 15;
   localparam int unsigned INSTR_W = 16;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: load has priority over increment; increment wraps.
module pc_reg #(
   parameter int unsigned ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] d,
   output logic [ADDR_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (inc) begin
         q <= q + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: one-cycle boot, request/ack fetch from instruction memory,
// then hold the instruction until the execute stage accepts it and the PC advances.
module pc_fetch #(
   parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
   parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pc_load,
   input  logic               pc_inc,
   input  logic [ADDR_W-1:0]  jmp_addr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [ADDR_W-1:0]  pc
);
   import cpu_pkg::fetch_state_e;
   import cpu_pkg::BOOT;
   import cpu_pkg::FETCH;
   import cpu_pkg::HOLD;

   fetch_state_e      state;
   fetch_state_e      state_next;
   logic              pc_ld;
   logic              pc_up;
   logic              instr_en;
   logic [ADDR_W-1:0] pc_q;

   // State register; request/valid flags are registered copies of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_next;
         imem_req    <= (state_next == FETCH);
         instr_valid <= (state_next == HOLD);
      end
   end

   // Next-state and control decode; ack and ready only matter in their own states.
   always_comb begin
      state_next = state;
      pc_ld      = 1'b0;
      pc_up      = 1'b0;
      instr_en   = 1'b0;
      case (state)
         BOOT: begin
            state_next = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               instr_en   = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (instr_ready) begin
               pc_ld      = pc_load;
               pc_up      = pc_inc;
               state_next = FETCH;
            end
         end
         default: begin
            state_next = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr <= '0;
      end else if (instr_en) begin
         instr <= imem_rdata;
      end
   end

   pc_reg #(
      .ADDR_W (ADDR_W)
   ) u_pc_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (pc_ld),
      .inc   (pc_up),
      .d     (jmp_addr),
      .q     (pc_q)
   );

   assign pc        = pc_q;
   assign imem_addr = pc_q;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter ADDR_W, default 15: program-counter and instruction-memory address width.
REQ-002 Parameter INSTR_W, default 16: instruction word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc_load  input  1  jump taken, from jump controller; sampled only on instruction accept.
REQ-006 pc_inc  input  1  sequential advance, from jump controller; sampled only on instruction accept.
REQ-007 jmp_addr  input  ADDR_W  jump target (A-register value); sampled only on instruction accept.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  ADDR_W  read address; equals pc while imem_req=1.
REQ-010 imem_ack  input  1  read data valid on imem_rdata this cycle.
REQ-011 imem_rdata  input  INSTR_W  instruction word from memory.
REQ-012 instr  output  INSTR_W  registered instruction presented to the execute stage.
REQ-013 instr_valid  output  1  instr holds a fetched, not-yet-consumed instruction.
REQ-014 instr_ready  input  1  execute stage consumes instr this cycle; jump-controller outputs valid this cycle.
REQ-015 pc  output  ADDR_W  current program counter (address of instr when instr_valid=1).

Function
REQ-016 The block SHALL implement FSM states BOOT, FETCH, HOLD.
REQ-017 BOOT SHALL last exactly one cycle after reset release, then go to FETCH; imem_req=0, instr_valid=0 in BOOT.
REQ-018 In FETCH the block SHALL assert imem_req=1 with imem_addr=pc every cycle until imem_ack=1 (unbounded wait states allowed).
REQ-019 On imem_ack=1 in FETCH, instr SHALL capture imem_rdata at that edge; next state HOLD; imem_req deasserts next cycle.
REQ-020 Minimum fetch latency SHALL be one cycle (ack in first FETCH cycle legal); instr_valid=1 the cycle after ack.
REQ-021 imem_ack outside FETCH SHALL be ignored; instr and pc unchanged.
REQ-022 In HOLD the block SHALL assert instr_valid=1, keep instr and pc stable, imem_req=0, until instr_ready=1.
REQ-023 instr_ready outside HOLD SHALL be ignored.
REQ-024 On accept (HOLD and instr_ready=1): pc_load=1 -> pc<=jmp_addr; else pc_inc=1 -> pc<=pc+1; else pc unchanged (same address refetched); next state FETCH.
REQ-025 pc_load=1 and pc_inc=1 simultaneously: load SHALL win.
REQ-026 Increment SHALL be modulo 2^ADDR_W: pc=0x7FFF with pc_inc -> 0x0000, no flag.
REQ-027 New imem_req for the updated pc SHALL appear the cycle after accept (one bubble cycle minimum between instructions: accept->req 1 cycle).
REQ-028 instr_valid SHALL be 0 in the cycle following accept and throughout FETCH.
REQ-029 All outputs SHALL be registered or decoded solely from state; no combinational path from any input to any output.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=BOOT, pc=0, instr=0, instr_valid=0, imem_req=0, imem_addr=0.
REQ-031 Reset mid-fetch or mid-hold SHALL abandon the pending request/instruction; a late imem_ack after reset release SHALL be ignored (BOOT).
REQ-032 First request after reset release SHALL be address 0 on the second rising edge.

Structure
REQ-033 Shared package cpu_pkg SHALL hold ADDR_W, INSTR_W defaults and the fetch-state enum type (BOOT, FETCH, HOLD).
REQ-034 One sub-module pc_reg (ADDR_W register with async active-low reset, load/inc/hold, load priority) SHALL be instantiated; FSM and instruction register live in pc_fetch.

Verification
REQ-035 Reset release, ack in first FETCH cycle, rdata=0x1234 -> imem_addr=0x0000, instr=0x1234, instr_valid=1 next cycle.
REQ-036 Accept with pc_inc=1 at pc=0x0005, memory 3 wait states -> imem_addr=0x0006 held 4 cycles, instr_valid=0 throughout.
REQ-037 Accept with pc_load=1, pc_inc=1, jmp_addr=0x0100 -> pc=0x0100, next imem_addr=0x0100.
REQ-038 pc=0x7FFF, accept with pc_inc=1 -> pc=0x0000; accept with both 0 -> same address refetched.
REQ-039 HOLD with instr_ready=0 for 10 cycles, spurious imem_ack pulses -> instr, pc, instr_valid=1 unchanged, imem_req=0.
REQ-040 rst_n pulsed low during FETCH at pc=0x0042, ack arriving in BOOT -> pc=0, ack ignored, first request address 0x0000.
